// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion sequencer and its capture slices.
package sar_pkg;

    localparam int unsigned MADC_DFLT = 17;
    localparam int unsigned CNT_W     = $clog2(MADC_DFLT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSamp,
        StComp,
        StUpdate,
        StWait
    } sar_state_e;

    // Zero or an over-range request both mean a full-length conversion.
    function automatic int unsigned clamp_ncycles(input int unsigned n, input int unsigned madc);
        return ((n == 0) || (n > madc)) ? madc : n;
    endfunction

endpackage

// File: rtl/sar_capture.sv
// One channel's successive-approximation code register: clear, single-bit write, and a
// look-ahead view of the value it will hold after the current edge.
module sar_capture #(
    parameter int unsigned Madc = 17,
    parameter int unsigned IdxW = $clog2(Madc + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_wr_en,
    input  logic [IdxW-1:0] i_idx,
    input  logic            i_bit,
    output logic [Madc-1:0] o_code_next
);

    logic [Madc-1:0] r_code;

    always_comb begin
        o_code_next = r_code;
        if (i_clr) begin
            o_code_next = '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < Madc; i++) begin
                if (i_idx == IdxW'(i)) begin
                    o_code_next[i] = i_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= '0;
        end else begin
            r_code <= o_code_next;
        end
    end

endmodule

// File: rtl/sar_sequencer.sv
// Multi-channel SAR ADC conversion controller: phase strobes, per-channel capture and a
// one-deep valid/ready result register.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned Madc  = 17,
    parameter int unsigned Nch   = 4,
    parameter int unsigned Wsamp = 4,
    localparam int unsigned CntW = $clog2(Madc + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CntW-1:0]     ncycles,
    input  logic [Wsamp-1:0]    samp_len,
    input  logic [Nch-1:0]      chan_en,
    input  logic [Nch-1:0]      comp_out,
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_comp,
    output logic                seq_update,
    output logic [Nch-1:0]      en_chan,
    output logic                busy,
    output logic [Nch*Madc-1:0] result,
    output logic                result_valid,
    input  logic                result_ready
);

    sar_state_e         r_state;
    logic [Wsamp-1:0]   r_samp_len;
    logic [Wsamp-1:0]   r_samp_cnt;
    logic [CntW-1:0]    r_k;
    logic [CntW-1:0]    r_nlast;
    logic [Nch-1:0]     r_mask;
    logic [Nch-1:0]     r_en_chan;
    logic               r_busy;
    logic               r_seq_init;
    logic               r_seq_samp;
    logic               r_seq_comp;
    logic               r_seq_update;
    logic [Nch*Madc-1:0] r_result;
    logic               r_valid;

    logic                w_clr;
    logic                w_wr;
    logic                w_last;
    logic                w_load;
    logic [CntW-1:0]     w_bit_idx;
    logic [Nch*Madc-1:0] w_codes;

    assign w_clr     = (r_state == StIdle) && start && !abort;
    assign w_wr      = (r_state == StUpdate) && !abort;
    assign w_last    = (r_k == r_nlast);
    assign w_bit_idx = CntW'(Madc - 1) - r_k;

    // A result loads when the last pair completes into a free slot, or when WAIT drains.
    assign w_load = !abort &&
        (((r_state == StUpdate) && w_last && !(r_valid && !result_ready)) ||
         ((r_state == StWait) && result_ready));

    for (genvar g = 0; g < Nch; g++) begin : g_cap
        sar_capture #(
            .Madc (Madc),
            .IdxW (CntW)
        ) u_cap (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr),
            .i_wr_en     (w_wr),
            .i_idx       (w_bit_idx),
            .i_bit       (comp_out[g] & r_mask[g]),
            .o_code_next (w_codes[g*Madc +: Madc])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_samp_len   <= '0;
            r_samp_cnt   <= '0;
            r_k          <= '0;
            r_nlast      <= '0;
            r_mask       <= '0;
            r_en_chan    <= '0;
            r_busy       <= 1'b0;
            r_seq_init   <= 1'b0;
            r_seq_samp   <= 1'b0;
            r_seq_comp   <= 1'b0;
            r_seq_update <= 1'b0;
        end else begin
            r_seq_init   <= 1'b0;
            r_seq_samp   <= 1'b0;
            r_seq_comp   <= 1'b0;
            r_seq_update <= 1'b0;
            if (abort) begin
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_en_chan <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start) begin
                            r_samp_len <= samp_len;
                            r_nlast    <= CntW'(clamp_ncycles(32'(ncycles), Madc) - 1);
                            r_mask     <= chan_en;
                            r_en_chan  <= chan_en;
                            r_k        <= '0;
                            r_busy     <= 1'b1;
                            r_seq_init <= 1'b1;
                            r_state    <= StInit;
                        end
                    end
                    StInit: begin
                        r_samp_cnt <= '0;
                        r_seq_samp <= 1'b1;
                        r_state    <= StSamp;
                    end
                    StSamp: begin
                        if (r_samp_cnt == r_samp_len) begin
                            r_seq_comp <= 1'b1;
                            r_state    <= StComp;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + 1'b1;
                            r_seq_samp <= 1'b1;
                        end
                    end
                    StComp: begin
                        r_seq_update <= 1'b1;
                        r_state      <= StUpdate;
                    end
                    StUpdate: begin
                        if (!w_last) begin
                            r_k        <= r_k + 1'b1;
                            r_seq_comp <= 1'b1;
                            r_state    <= StComp;
                        end else begin
                            r_en_chan <= '0;
                            if (r_valid && !result_ready) begin
                                r_state <= StWait;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    StWait: begin
                        if (result_ready) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_busy    <= 1'b0;
                        r_en_chan <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_result <= w_codes;
            r_valid  <= 1'b1;
        end else if (r_valid && result_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign seq_init     = r_seq_init;
    assign seq_samp     = r_seq_samp;
    assign seq_comp     = r_seq_comp;
    assign seq_update   = r_seq_update;
    assign en_chan      = r_en_chan;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule
